sim_clkgen_multi: RTL and testbench
===================================

Name: sim_clkgen_multi

Overview:
- Parametrised multi-channel clock generator for simulation and FPGA-friendly builds.
- Derives NUM_CH divided clocks from one reference clock. Each channel has its own integer divide ratio and phase offset, counted in reference cycles.
- Adds behaviour beyond a fixed free-running clocker: per-channel enable, glitch-free stop, runtime reconfiguration through a valid/ready port, rising-edge strobes and a per-channel lock indication.
- Feeds sim clock domains and clock-enable fabric.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 16, width of the divide and phase counters.
- DIV_INIT, {NUM_CH{16'd2}}, packed reset divide ratio per channel; each must be >= 2.
- PHASE_INIT, {NUM_CH{16'd0}}, packed reset phase offset per channel, in reference cycles.

Ports:
- clk  in  1  reference clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable (level).
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  configuration accept.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  CNT_W  new divide ratio.
- cfg_phase  in  CNT_W  new phase offset.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- clk_out  out  NUM_CH  registered divided clocks.
- rise_stb  out  NUM_CH  one-cycle pulse in the cycle clk_out goes 0->1.
- locked  out  NUM_CH  channel is running with its current configuration applied.

Behaviour:
- Reset (async assert, sync release): all of clk_out, rise_stb, locked, cfg_err are 0; cfg_ready is 1. Every channel is in IDLE with div=DIV_INIT[i], phase=PHASE_INIT[i], and no pending config.
- Per-channel state machine IDLE -> DELAY -> RUN -> STOP -> IDLE:
  - IDLE: clk_out=0. When ch_en is sampled 1 at edge T: go to DELAY with pcnt=phase, or to RUN with cnt=0 if phase=0.
  - DELAY: pcnt decrements each cycle; on reaching 0, enter RUN with cnt=0. The first high cycle therefore occurs in cycle T+1+phase.
  - RUN: cnt counts 0..div-1 and wraps. clk_out=1 while cnt < (div>>1), otherwise 0, so odd ratios have the shorter high half. rise_stb=1 in the cycle cnt==0.
  - STOP: entered when ch_en is sampled 0 while in RUN or DELAY. From DELAY, return to IDLE immediately. From RUN, continue until cnt==div-1, then go to IDLE, so no runt high pulse is produced.
  - Re-assert during STOP: return to RUN without a gap.
- locked=1 from the first wrap (cnt==div-1) in RUN with no pending config; it clears on leaving RUN or when a config is latched for the channel.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready=0 only while the addressed cfg_ch already holds a pending config.
  - cfg_div<2: the request is accepted, discarded, and cfg_err pulses in the next cycle.
- Applying a config:
  - IDLE channel: applied at the accept edge.
  - RUN channel: held pending and applied at the next wrap (cnt==div-1). The new period starts with the new div; the new phase applies as a DELAY inserted before cnt=0.
  - DELAY channel: applied on DELAY completion.
- Simultaneous events: if a wrap and an accept to the same channel occur in the same cycle, the new config becomes pending and takes effect at the following wrap. A ch_en drop has priority over applying a pending config; the pending config is applied on reaching IDLE.
- Channels are fully independent. There is no cross-channel phase alignment beyond a common enable edge.

Decomposition:
- Package sim_clkgen_pkg: state enum (IDLE, DELAY, RUN, STOP), CNT_W default, and a function div_high(div) returning div>>1.
- Sub-module sim_clkgen_chan: one channel's FSM, counters, pending-config register and outputs. It is instantiated NUM_CH times.
- The top level holds the config decode, cfg_ready mux and cfg_err register.

Test Plan:
- div=4, phase=0, ch_en rises at edge 0 -> clk_out 1,1,0,0 repeating from cycle 1; rise_stb at cycles 1,5,9; locked=1 from cycle 4.
- div=5, phase=3 -> first high at cycle 4; high 2 cycles, low 3; period 5.
- RUN at div=4, config div=6 accepted mid-period -> current period completes as 4; next periods are 3 high / 3 low; locked drops at accept and returns at the first div-6 wrap.
- ch_en drops at cnt=1 (div=8) -> clk_out completes high cycles 0..3 and low cycles 4..7, then stays 0; no extra rise_stb.
- cfg_div=1 -> cfg_err pulses once, channel behaviour unchanged. A second request to a channel with a pending config sees cfg_ready=0 until that channel's wrap.
- rst_n asserted mid-RUN asynchronously -> clk_out and locked are 0 immediately; after release, a channel with ch_en held at 1 restarts from the DIV_INIT/PHASE_INIT timing.

Source files
------------

// File: rtl/sim_clkgen_pkg.sv
// sim_clkgen_pkg
// Shared definitions for the multi-channel clock generator:
//   - chan_state_t : per-channel FSM state (IDLE, DELAY, RUN, STOP)
//   - CNT_W_DEF    : default width of the divide and phase counters
//   - div_high()   : number of high cycles in one period (div >> 1);
//                    odd ratios therefore get the shorter high half
package sim_clkgen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } chan_state_t;

  function automatic logic [31:0] div_high(input logic [31:0] div);
    return div >> 1;
  endfunction

endpackage

// File: rtl/sim_clkgen_chan.sv
// sim_clkgen_chan
// One divided-clock channel: FSM, period/phase counters, pending-config
// register and registered outputs.
// Ports:
//   clk, rst_n        reference clock, asynchronous active-low reset
//   i_en              run enable (level)
//   i_cfg_acc         a valid config (div >= 2) is accepted for this channel
//   i_cfg_div/phase   config payload
//   o_pending         a config is held waiting for the next wrap
//   o_clk             divided clock (registered)
//   o_rise            one-cycle strobe in the cycle o_clk goes 0->1
//   o_locked          running with its current configuration applied
module sim_clkgen_chan
  import sim_clkgen_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_INIT   = CNT_W'(2),
  parameter logic [CNT_W-1:0] PHASE_INIT = CNT_W'(0)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_cfg_acc,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_phase,
  output logic             o_pending,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_locked
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  chan_state_t      r_state, w_state_next;
  logic [CNT_W-1:0] r_div, w_div_next;
  logic [CNT_W-1:0] r_phase, w_phase_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_pcnt, w_pcnt_next;
  logic [CNT_W-1:0] r_pdiv, w_pdiv_next;
  logic [CNT_W-1:0] r_pphase, w_pphase_next;
  logic             r_pend, w_pend_next;
  logic             r_locked, w_locked_next;
  logic             r_clk, r_rise;
  logic             w_apply;
  logic             w_wrap;
  logic             w_active;
  logic [CNT_W-1:0] w_half;

  assign w_half   = CNT_W'(div_high(32'(r_div)));
  assign w_wrap   = (r_cnt == (r_div - ONE));
  assign w_active = (r_state == ST_RUN) || (r_state == ST_STOP);

  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_phase_next  = r_phase;
    w_cnt_next    = r_cnt;
    w_pcnt_next   = r_pcnt;
    w_pdiv_next   = r_pdiv;
    w_pphase_next = r_pphase;
    w_pend_next   = r_pend;
    w_locked_next = r_locked;
    w_apply       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A pending config can still be here if it was accepted on the
        // same edge the channel dropped into IDLE.
        if (r_pend) begin
          w_div_next   = r_pdiv;
          w_phase_next = r_pphase;
          w_pend_next  = 1'b0;
        end
        if (i_cfg_acc) begin
          w_div_next   = i_cfg_div;
          w_phase_next = i_cfg_phase;
        end
        // Start with whatever config is in force after this edge.
        if (i_en) begin
          if (w_phase_next == '0) begin
            w_state_next = ST_RUN;
            w_cnt_next   = '0;
          end else begin
            w_state_next = ST_DELAY;
            w_pcnt_next  = w_phase_next;
          end
        end
      end

      ST_DELAY: begin
        if (!i_en) begin
          w_state_next = ST_IDLE;
          w_apply      = r_pend;
        end else if (r_pcnt <= ONE) begin
          // Last delay cycle: cnt=0 is the first RUN cycle after this edge.
          w_state_next = ST_RUN;
          w_cnt_next   = '0;
          w_apply      = r_pend;
        end else begin
          w_pcnt_next = r_pcnt - ONE;
        end
      end

      ST_RUN, ST_STOP: begin
        if (!i_en) begin
          // Finish the current period so no runt high pulse appears.
          if (w_wrap) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_apply      = r_pend;
          end else begin
            w_state_next = ST_STOP;
            w_cnt_next   = r_cnt + ONE;
          end
        end else begin
          // Enabled: RUN continues, STOP resumes without a gap.
          w_state_next = ST_RUN;
          if (w_wrap) begin
            w_cnt_next = '0;
            w_apply    = r_pend;
            if (r_pend && (r_pphase != '0)) begin
              w_state_next = ST_DELAY;
              w_pcnt_next  = r_pphase;
            end
          end else begin
            w_cnt_next = r_cnt + ONE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_apply) begin
      w_div_next   = r_pdiv;
      w_phase_next = r_pphase;
      w_pend_next  = 1'b0;
    end

    // Outside IDLE a new config waits for the next safe point.
    if (i_cfg_acc && (r_state != ST_IDLE)) begin
      w_pend_next   = 1'b1;
      w_pdiv_next   = i_cfg_div;
      w_pphase_next = i_cfg_phase;
    end

    if (w_state_next != ST_RUN) begin
      w_locked_next = 1'b0;
    end else if (w_active && w_wrap && !r_pend) begin
      w_locked_next = 1'b1;
    end
    if (i_cfg_acc) begin
      w_locked_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_div    <= DIV_INIT;
      r_phase  <= PHASE_INIT;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_pdiv   <= '0;
      r_pphase <= '0;
      r_pend   <= 1'b0;
      r_locked <= 1'b0;
      r_clk    <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_phase  <= w_phase_next;
      r_cnt    <= w_cnt_next;
      r_pcnt   <= w_pcnt_next;
      r_pdiv   <= w_pdiv_next;
      r_pphase <= w_pphase_next;
      r_pend   <= w_pend_next;
      r_locked <= w_locked_next;
      // Outputs are registered from the current count, one cycle behind it.
      r_clk    <= w_active && (r_cnt < w_half);
      r_rise   <= w_active && (r_cnt == '0);
    end
  end

  assign o_pending = r_pend;
  assign o_clk     = r_clk;
  assign o_rise    = r_rise;
  assign o_locked  = r_locked;

endmodule

// File: rtl/sim_clkgen_multi.sv
// sim_clkgen_multi
// NUM_CH independent divided clocks from one reference clock, with
// per-channel enable, glitch-free stop and runtime reconfiguration.
// Ports:
//   clk, rst_n          reference clock, asynchronous active-low reset
//   ch_en               per-channel run enable
//   cfg_valid/ready     config handshake; ready drops only while the
//                       addressed channel already holds a pending config
//   cfg_ch/div/phase    config target and payload
//   cfg_err             one-cycle pulse after a rejected (div<2) request
//   clk_out, rise_stb   divided clocks and their rising-edge strobes
//   locked              channel running with its current config applied
module sim_clkgen_multi
  import sim_clkgen_pkg::*;
#(
  parameter int                      NUM_CH     = 4,
  parameter int                      CNT_W      = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT   = {NUM_CH{CNT_W'(2)}},
  parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT = {NUM_CH{CNT_W'(0)}},
  localparam int                     CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] locked
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_acc;
  logic              w_sel_ok;
  logic              w_div_ok;
  logic              w_xfer;
  logic              r_cfg_err;

  // Channel numbers past NUM_CH can only exist for non-power-of-two counts;
  // such requests are accepted and flagged as errors.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_range
      assign w_sel_ok = (32'(cfg_ch) < NUM_CH);
    end
  endgenerate

  assign cfg_ready = w_sel_ok ? ~w_pending[cfg_ch] : 1'b1;
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_div_ok  = (cfg_div >= CNT_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !(w_div_ok && w_sel_ok);
    end
  end

  assign cfg_err = r_cfg_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_acc[gi] = w_xfer && w_div_ok && (cfg_ch == CH_W'(gi));

      sim_clkgen_chan #(
        .CNT_W      (CNT_W),
        .DIV_INIT   (DIV_INIT[gi*CNT_W +: CNT_W]),
        .PHASE_INIT (PHASE_INIT[gi*CNT_W +: CNT_W])
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (ch_en[gi]),
        .i_cfg_acc   (w_acc[gi]),
        .i_cfg_div   (cfg_div),
        .i_cfg_phase (cfg_phase),
        .o_pending   (w_pending[gi]),
        .o_clk       (clk_out[gi]),
        .o_rise      (rise_stb[gi]),
        .o_locked    (locked[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sim_clkgen_multi.sv
// Testbench for sim_clkgen_multi. Channel reset configs:
//   ch0 div=4 phase=0, ch1 div=5 phase=3, ch2 div=8 phase=0, ch3 div=2 phase=0
module tb_sim_clkgen_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_en = 4'b0000;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = 2'd0;
  logic [15:0] cfg_div = 16'd0;
  logic [15:0] cfg_phase = 16'd0;
  logic        cfg_err;
  logic [3:0]  clk_out;
  logic [3:0]  rise_stb;
  logic [3:0]  locked;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] clk;
    logic [1:0] rise;
    logic [1:0] lock;
  } vec_t;

  vec_t tbl [13];

  always #5 clk = ~clk;

  sim_clkgen_multi #(
    .NUM_CH     (4),
    .CNT_W      (16),
    .DIV_INIT   ({16'd2, 16'd8, 16'd5, 16'd4}),
    .PHASE_INIT ({16'd0, 16'd0, 16'd3, 16'd0})
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_stb  (rise_stb),
    .locked    (locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one reference cycle and land mid-cycle for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ch0 (div4,ph0) and ch1 (div5,ph3) started together; row k is the cycle
  // after the k-th rising edge, edge 0 being the first to sample ch_en=1.
  task automatic run_table(input string tag);
    for (int k = 0; k < 13; k++) begin
      tick();
      chk($sformatf("%s_clk_k%0d", tag, k),  32'(clk_out[1:0]),  32'(tbl[k].clk));
      chk($sformatf("%s_rise_k%0d", tag, k), 32'(rise_stb[1:0]), 32'(tbl[k].rise));
      chk($sformatf("%s_lock_k%0d", tag, k), 32'(locked[1:0]),   32'(tbl[k].lock));
    end
    $display("table %s: 13 cycles applied", tag);
  endtask

  initial begin
    logic [9:0] b_clk;

    tbl[0]  = '{2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b01, 2'b01, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 2'b00};
    tbl[3]  = '{2'b00, 2'b00, 2'b00};
    tbl[4]  = '{2'b10, 2'b10, 2'b01};
    tbl[5]  = '{2'b11, 2'b01, 2'b01};
    tbl[6]  = '{2'b01, 2'b00, 2'b01};
    tbl[7]  = '{2'b00, 2'b00, 2'b01};
    tbl[8]  = '{2'b00, 2'b00, 2'b11};
    tbl[9]  = '{2'b11, 2'b11, 2'b11};
    tbl[10] = '{2'b11, 2'b00, 2'b11};
    tbl[11] = '{2'b00, 2'b00, 2'b11};
    tbl[12] = '{2'b00, 2'b00, 2'b11};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_rise",    32'(rise_stb), 32'd0);
    chk("rst_locked",  32'(locked), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_ready",   32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("idle_clk_out", 32'(clk_out), 32'd0);

    // A: basic divide and phase timing
    ch_en = 4'b0011;
    run_table("tA");

    // B: ch0 div4 -> div6 mid-period, second request stalls on ready
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6; cfg_phase = 16'd0;
    chk("b_ready_free", 32'(cfg_ready), 32'd1);
    $display("cfg request ch=0 div=6 phase=0");
    tick();
    cfg_div = 16'd8;
    $display("cfg request ch=0 div=8 phase=0 (expected to stall)");
    chk("b_ready_busy", 32'(cfg_ready), 32'd0);
    chk("b_lock_drop",  32'(locked[0]), 32'd0);
    chk("b_clk_c13",    32'(clk_out[0]), 32'd1);
    b_clk = 10'b1000111001;
    for (int j = 14; j <= 23; j++) begin
      tick();
      chk($sformatf("b_clk_c%0d", j),  32'(clk_out[0]),  32'(b_clk[j-14]));
      chk($sformatf("b_rise_c%0d", j), 32'(rise_stb[0]), 32'(j == 17 || j == 23));
      chk($sformatf("b_lock_c%0d", j), 32'(locked[0]),   32'(j >= 22));
      if (j <= 16) begin
        chk($sformatf("b_ready_c%0d", j), 32'(cfg_ready), 32'(j == 16));
      end
      if (j == 16) begin
        cfg_valid = 1'b0;
        $display("cfg request ch=0 div=8 withdrawn");
      end
    end

    // C: ch2 div8 started, ch_en dropped when cnt=1 -> full period, no runt
    ch_en = 4'b0111;
    for (int r = 0; r <= 16; r++) begin
      tick();
      chk($sformatf("c_clk_r%0d", r),  32'(clk_out[2]),  32'(r >= 1 && r <= 4));
      chk($sformatf("c_rise_r%0d", r), 32'(rise_stb[2]), 32'(r == 1));
      chk($sformatf("c_lock_r%0d", r), 32'(locked[2]),   32'd0);
      if (r == 1) ch_en[2] = 1'b0;
    end

    // D: div=1 rejected with one cfg_err pulse, ch2 still divides by 8
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd1; cfg_phase = 16'd0;
    $display("cfg request ch=2 div=1 phase=0 (invalid)");
    chk("d_ready",   32'(cfg_ready), 32'd1);
    chk("d_err_pre", 32'(cfg_err), 32'd0);
    tick();
    chk("d_err_pulse", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    ch_en[2] = 1'b1;
    tick();
    chk("d_err_clear", 32'(cfg_err), 32'd0);
    for (int r = 1; r <= 9; r++) begin
      tick();
      chk($sformatf("d_clk_r%0d", r), 32'(clk_out[2]), 32'(r <= 4 || r == 9));
    end

    // E: asynchronous reset mid-run, then restart from init timing
    chk("e_pre_lock", 32'(locked[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_clk_out", 32'(clk_out), 32'd0);
    chk("e_rst_locked",  32'(locked), 32'd0);
    chk("e_rst_rise",    32'(rise_stb), 32'd0);
    chk("e_rst_ready",   32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_table("tE");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
